// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the rv32i core (FETCH/DECODE/EXEC/MEM/WB over one shared memory port).
// Define PERF_CNT_EN to build the retired-instruction counter behind the instret port.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT   = 64,
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [2:0]  imm_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state_o,
  output logic        retire,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // The stall that would make the count reach MEM_TIMEOUT is the one that faults.
  localparam logic [7:0] TMO_LAST  = 8'(MEM_TIMEOUT - 1);
  localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

  state_e      state_q, state_d;
  logic [3:0]  hold_q, hold_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [6:0]  opc_s;
  logic [2:0]  imm_fmt_s;
  logic        legal_s;
  logic        unused_instr_s;

  assign opc_s          = instr[6:0];
  assign unused_instr_s = ^instr[31:7];

  // Opcode legality and immediate format.
  always_comb begin
    imm_fmt_s = 3'd0;
    legal_s   = 1'b1;
    case (opc_s)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: imm_fmt_s = 3'd1;
      OPC_STORE:                     imm_fmt_s = 3'd2;
      OPC_BRANCH:                    imm_fmt_s = 3'd3;
      OPC_LUI, OPC_AUIPC:            imm_fmt_s = 3'd4;
      OPC_JAL:                       imm_fmt_s = 3'd5;
      OPC_OP, OPC_FENCE:             imm_fmt_s = 3'd0;
      default:                       legal_s   = 1'b0;
    endcase
  end

  // Next state, counters and per-state datapath strobes.
  always_comb begin
    state_d      = state_q;
    hold_d       = 4'd0;
    tmo_d        = 8'd0;
    fault_code_d = fault_code_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    rf_we        = 1'b0;
    imm_sel      = 3'd0;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    wb_sel       = 2'd0;
    retire       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hold_q == HOLD_LAST) state_d = S_FETCH;
        else                     hold_d  = hold_q + 4'd1;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d      = S_FAULT;
          fault_code_d = 2'd2;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DECODE: begin
        imm_sel = imm_fmt_s;
        if (legal_s) begin
          state_d = S_EXEC;
        end else begin
          state_d      = S_FAULT;
          fault_code_d = 2'd1;
        end
      end
      S_EXEC: begin
        imm_sel = imm_fmt_s;
        case (opc_s)
          OPC_OP:              state_d = S_WB;
          OPC_LUI:             state_d = S_WB;
          OPC_OPIMM, OPC_JALR: begin alu_src_b = 1'b1; state_d = S_WB; end
          OPC_LOAD, OPC_STORE: begin alu_src_b = 1'b1; state_d = S_MEM; end
          OPC_AUIPC, OPC_JAL: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          OPC_BRANCH: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
            pc_we     = 1'b1;
            pc_sel    = {1'b0, branch_taken};
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
          OPC_FENCE: begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
            state_d      = S_FAULT;
            fault_code_d = 2'd1;
          end
        endcase
      end
      S_MEM: begin
        imm_sel = imm_fmt_s;
        mem_req = 1'b1;
        mem_we  = (opc_s == OPC_STORE);
        if (mem_ready) begin
          if (opc_s == OPC_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d      = S_FAULT;
          fault_code_d = 2'd2;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WB: begin
        imm_sel = imm_fmt_s;
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        case (opc_s)
          OPC_LOAD: wb_sel = 2'd1;
          OPC_JAL:  begin wb_sel = 2'd2; pc_sel = 2'd1; end
          OPC_JALR: begin wb_sel = 2'd2; pc_sel = 2'd2; end
          OPC_LUI:  wb_sel = 2'd3;
          default:  wb_sel = 2'd0;
        endcase
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state; FAULT is left only through rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hold_q       <= 4'd0;
      tmo_q        <= 8'd0;
      fault_code_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      tmo_q        <= tmo_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign state_o    = state_q;
  assign fault      = (state_q == S_FAULT);
  assign fault_code = fault_code_q;

`ifdef PERF_CNT_EN
  logic [31:0] instret_q, instret_d;

  always_comb begin
    if (retire) instret_d = instret_q + 32'd1;
    else        instret_d = instret_q;
  end

  // Retired-instruction count, wrapping at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= 32'd0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the rv32i core. It sequences one shared memory port, the register file, the ALU and the immediate generator through FETCH/DECODE/EXEC/MEM/WB. It decodes the latched instruction into per-state datapath strobes, including the immediate-format select. It also detects illegal opcodes and memory-handshake timeouts.

Parameters:
MEM_TIMEOUT, 64, maximum consecutive cycles with mem_req=1 and mem_ready=0 before fault (1..255)
RESET_PC_HOLD, 1, cycles spent in IDLE after reset release before the first FETCH (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction register contents; stable after the ir_we cycle
mem_ready  in  1  memory completes the current request this cycle
branch_taken  in  1  ALU compare result, valid in EXEC
mem_req  out  1  memory request (fetch or data)
mem_we  out  1  store strobe, qualified by mem_req
ir_we  out  1  load instruction register
pc_we  out  1  update PC (one pulse per instruction)
pc_sel  out  2  0=pc+4, 1=pc+imm, 2=(rs1+imm)&~1
rf_we  out  1  register-file write
imm_sel  out  3  0=none, 1=I, 2=S, 3=B, 4=U, 5=J
alu_src_a  out  1  0=rs1, 1=pc
alu_src_b  out  1  0=rs2, 1=imm
wb_sel  out  2  0=alu, 1=mem data, 2=pc+4, 3=imm
state_o  out  3  current state encoding, for debug
retire  out  1  instruction-completion pulse
fault  out  1  sticky fault flag
fault_code  out  2  0=none, 1=illegal opcode, 2=memory timeout
instret  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, timeout counter=0, fault=0, fault_code=0, instret=0. All strobes are 0, pc_sel=0, imm_sel=0, wb_sel=0, alu_src_a=0, alu_src_b=0.
- Reset asserted mid-operation aborts immediately to IDLE. No partial strobes are emitted after release.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7. Outputs are combinational from the state register and instr[6:0].
- IDLE: hold RESET_PC_HOLD cycles, then go to FETCH.
- FETCH: mem_req=1, mem_we=0. The request is held until mem_ready=1; in that cycle ir_we=1 and the next state is DECODE. mem_ready while mem_req=0 is ignored.
- DECODE: one cycle. imm_sel is set from the opcode: LOAD/OPIMM/JALR=I, STORE=S, BRANCH=B, LUI/AUIPC=U, JAL=J, OP=none. An opcode outside {0000011, 0100011, 0010011, 0110011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111} goes to FAULT with code 1.
- EXEC: imm_sel is held from DECODE through WB/MEM.
  - OP: src_b=0. OPIMM/LOAD/STORE/JALR: src_b=1. AUIPC/JAL/BRANCH: src_a=1 (target calculation).
  - LOAD/STORE go to MEM. OP/OPIMM/LUI/AUIPC/JAL/JALR go to WB.
  - BRANCH: pc_we=1, pc_sel=1 if branch_taken else 0, retire=1, next state FETCH.
  - FENCE (0001111): treated as a NOP; pc_we=1, pc_sel=0, retire=1, next state FETCH.
- MEM: mem_req=1, mem_we=1 for STORE. Held until mem_ready.
  - STORE completes: pc_we=1, pc_sel=0, retire=1, next state FETCH.
  - LOAD completes: next state WB.
- WB: rf_we=1, pc_we=1, retire=1, next state FETCH.
  - wb_sel: LOAD=1, JAL/JALR=2, LUI=3, others=0.
  - pc_sel: JAL=1, JALR=2, others=0.
- Timeout counter:
  - Increments each cycle with mem_req=1 and mem_ready=0.
  - Clears on a completed transfer or on leaving FETCH/MEM.
  - The cycle the counter reaches MEM_TIMEOUT, mem_ready=0 goes to FAULT with code 2. If mem_ready=1 in that same cycle, completion wins.
- FAULT: all strobes 0, fault=1, fault_code held. Exit only via reset.
- Rules: pc_we and retire pulse exactly once per non-faulting instruction, in the same cycle. The faulting instruction never asserts rf_we, pc_we or retire.

Optional Feature:
PERF_CNT_EN
- Defined: instret increments by 1 on every retire pulse and wraps from 0xFFFF_FFFF to 0. It is reset to 0.
- Undefined: instret is tied to 0 and no counter flops exist.
- The port is present in both builds.

Test Plan:
- Reset then release, ADDI (0x00500093), mem_ready returned one cycle after each request -> first mem_req exactly RESET_PC_HOLD cycles after release. Sequence FETCH(2)/DECODE/EXEC/WB; rf_we, pc_we and retire in WB; imm_sel=1; alu_src_b=1.
- LW (0x0000A103) with 2 wait states in MEM -> mem_req held 3 cycles with mem_we=0; WB has wb_sel=1, rf_we=1; one retire.
- BEQ (0x00000463) with branch_taken=1, then with branch_taken=0 -> EXEC pc_we=1 with pc_sel=1, then 0; imm_sel=3; rf_we never asserted.
- Instruction 0x00000073 (SYSTEM) -> FAULT after DECODE; fault_code=1; no pc_we/retire; FAULT held until rst_n=0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=4 -> FAULT entered after 4 stalled cycles, fault_code=2. Repeat with mem_ready=1 on the 4th cycle -> normal DECODE.
- With PERF_CNT_EN, 5 mixed instructions -> instret=5. Pulse rst_n mid-MEM -> instret=0 and state=IDLE asynchronously.
